div_scheduler: RTL and testbench

Round-robin scheduler that shares the single 16-bit iterative divider among NCH requesters, such as the per-channel step-rate calculations.
- Latches the granted requester's operands and sequences the divider's go/done protocol.
- Filters divide-by-zero before launch and bounds each operation with a timeout.
- Returns the quotient with a one-cycle ack to the originating requester.

---
 rtl/div_scheduler.sv | 172 +++++++++++++++++
 tb/tb_div_scheduler.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_scheduler.sv
// Round-robin arbiter sharing one iterative 16-bit divider among NCH requesters.
// Filters divide-by-zero before launch, bounds each operation with a timeout.
module div_scheduler #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned TIMEOUT = 512
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH-1:0]    req_i,
    input  logic [16*NCH-1:0] req_divisor_i,
    input  logic [16*NCH-1:0] req_dividend_i,
    output logic [NCH-1:0]    ack_o,
    output logic              resp_valid_o,
    output logic [2:0]        resp_ch_o,
    output logic [15:0]       resp_quotient_o,
    output logic              resp_err_o,
    output logic              busy_o,
    output logic              div_go_o,
    output logic [15:0]       div_divisor_o,
    output logic [15:0]       div_dividend_o,
    input  logic [15:0]       div_quotient_i,
    input  logic              div_done_i
);

    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StLaunch, StSettle, StWait, StDone} state_e;

    state_e          state_q;
    logic [2:0]      ptr_q;
    logic [2:0]      ch_q;
    logic [CntW-1:0] cnt_q;
    logic [NCH-1:0]  ack_q;
    logic            resp_valid_q;
    logic [2:0]      resp_ch_q;
    logic [15:0]     resp_quotient_q;
    logic            resp_err_q;
    logic            div_go_q;
    logic [15:0]     div_divisor_q;
    logic [15:0]     div_dividend_q;

    logic [NCH-1:0]  req_rot;
    logic            grant_vld;
    logic [3:0]      grant_sum;
    logic [2:0]      grant_ch;
    logic [2:0]      ptr_nxt;
    logic [NCH-1:0]  grant_oh;
    logic [NCH-1:0]  ch_oh;
    logic [15:0]     sel_divisor;
    logic [15:0]     sel_dividend;

    // Rotate requests so bit 0 is the pointer position; first set bit wins.
    always_comb begin
        req_rot   = NCH'({req_i, req_i} >> ptr_q);
        grant_vld = 1'b0;
        grant_sum = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!grant_vld && req_rot[i]) begin
                grant_vld = 1'b1;
                grant_sum = {1'b0, ptr_q} + 4'(i);
            end
        end
        if (grant_sum >= 4'(NCH)) begin
            grant_sum = grant_sum - 4'(NCH);
        end
        grant_ch     = grant_sum[2:0];
        ptr_nxt      = (grant_ch == 3'(NCH - 1)) ? 3'd0 : grant_ch + 3'd1;
        grant_oh     = '0;
        ch_oh        = '0;
        sel_divisor  = '0;
        sel_dividend = '0;
        for (int unsigned j = 0; j < NCH; j++) begin
            grant_oh[j] = (grant_ch == 3'(j));
            ch_oh[j]    = (ch_q == 3'(j));
            if (grant_ch == 3'(j)) begin
                sel_divisor  = req_divisor_i[16*j +: 16];
                sel_dividend = req_dividend_i[16*j +: 16];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            ptr_q           <= '0;
            ch_q            <= '0;
            cnt_q           <= '0;
            ack_q           <= '0;
            resp_valid_q    <= 1'b0;
            resp_ch_q       <= '0;
            resp_quotient_q <= '0;
            resp_err_q      <= 1'b0;
            div_go_q        <= 1'b0;
            div_divisor_q   <= '0;
            div_dividend_q  <= '0;
        end else begin
            // Response and go are single-cycle pulses unless reloaded below.
            ack_q           <= '0;
            resp_valid_q    <= 1'b0;
            resp_ch_q       <= '0;
            resp_quotient_q <= '0;
            resp_err_q      <= 1'b0;
            div_go_q        <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_vld) begin
                        ch_q           <= grant_ch;
                        ptr_q          <= ptr_nxt;
                        div_divisor_q  <= sel_divisor;
                        div_dividend_q <= sel_dividend;
                        if (sel_divisor == 16'd0) begin
                            state_q         <= StDone;
                            ack_q           <= grant_oh;
                            resp_valid_q    <= 1'b1;
                            resp_ch_q       <= grant_ch;
                            resp_quotient_q <= 16'hFFFF;
                            resp_err_q      <= 1'b1;
                        end else begin
                            state_q  <= StLaunch;
                            div_go_q <= 1'b1;
                        end
                    end
                end
                StLaunch: begin
                    state_q <= StSettle;
                end
                StSettle: begin
                    // Divider output is stale here; done is not trusted yet.
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (div_done_i) begin
                        state_q         <= StDone;
                        ack_q           <= ch_oh;
                        resp_valid_q    <= 1'b1;
                        resp_ch_q       <= ch_q;
                        resp_quotient_q <= div_quotient_i;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        state_q         <= StDone;
                        ack_q           <= ch_oh;
                        resp_valid_q    <= 1'b1;
                        resp_ch_q       <= ch_q;
                        resp_quotient_q <= 16'hFFFF;
                        resp_err_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_q        <= StIdle;
                    div_divisor_q  <= '0;
                    div_dividend_q <= '0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ack_o           = ack_q;
    assign resp_valid_o    = resp_valid_q;
    assign resp_ch_o       = resp_ch_q;
    assign resp_quotient_o = resp_quotient_q;
    assign resp_err_o      = resp_err_q;
    assign busy_o          = (state_q != StIdle);
    assign div_go_o        = div_go_q;
    assign div_divisor_o   = div_divisor_q;
    assign div_dividend_o  = div_dividend_q;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: behavioural divider with programmable latency, plus
// scenario tasks and a randomized round-robin run against a queue-level model.
module tb_div_scheduler;
    localparam int unsigned NCH     = 4;
    localparam int unsigned TIMEOUT = 512;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    req = '0;
    logic [16*NCH-1:0] req_divisor = '0;
    logic [16*NCH-1:0] req_dividend = '0;
    logic [NCH-1:0]    ack;
    logic              resp_valid;
    logic [2:0]        resp_ch;
    logic [15:0]       resp_quotient;
    logic              resp_err;
    logic              busy;
    logic              div_go;
    logic [15:0]       div_divisor;
    logic [15:0]       div_dividend;
    logic [15:0]       div_quotient;
    logic              div_done;

    int n_checks = 0;
    int n_fail   = 0;

    div_scheduler #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_i           (req),
        .req_divisor_i   (req_divisor),
        .req_dividend_i  (req_dividend),
        .ack_o           (ack),
        .resp_valid_o    (resp_valid),
        .resp_ch_o       (resp_ch),
        .resp_quotient_o (resp_quotient),
        .resp_err_o      (resp_err),
        .busy_o          (busy),
        .div_go_o        (div_go),
        .div_divisor_o   (div_divisor),
        .div_dividend_o  (div_dividend),
        .div_quotient_i  (div_quotient),
        .div_done_i      (div_done)
    );

    always #5 clk = ~clk;

    // cyc at a negedge is the index of the current cycle; go/ack activity logged per cycle
    int unsigned cyc = 0, go_cnt = 0, last_go = 0, act_cnt = 0;
    always @(posedge clk) begin
        if (div_go) begin
            go_cnt  <= go_cnt + 1;
            last_go <= cyc;
        end
        if (resp_valid || ack != '0) act_cnt <= act_cnt + 1;
        cyc <= cyc + 1;
    end

    // Divider model: done appears lat cycles after SETTLE begins, stale done held until then
    int unsigned lat = 1, m = 0;
    bit          stuck = 1'b0;
    logic [15:0] mq = '0;
    logic        mdone = 1'b0;
    always @(posedge clk) begin
        if (div_go) begin
            m  <= lat;
            mq <= (div_divisor == 16'd0) ? 16'hFFFF : div_dividend / div_divisor;
        end else if (m != 0) begin
            mdone <= (m == 1) && !stuck;
            m     <= m - 1;
        end
    end
    assign div_quotient = mq;
    assign div_done     = mdone;

    task automatic set_op(input int unsigned ch, input logic [15:0] dvs, input logic [15:0] dvd);
        req_divisor[16*ch +: 16]  = dvs;
        req_dividend[16*ch +: 16] = dvd;
    endtask

    task automatic wait_resp(input int unsigned budget, output bit ok, output int unsigned at);
        ok = 1'b0;
        at = 0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ack, resp_valid, busy, div_go} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0", {ack, resp_valid, busy, div_go});
        end
        n_checks++;
        if ({resp_ch, resp_quotient, resp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: got %h want 0", {resp_ch, resp_quotient, resp_err});
        end
        n_checks++;
        if ({div_divisor, div_dividend} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_divbus: got %h want 0", {div_divisor, div_dividend});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_single();
        bit ok;
        int unsigned n, at, g0;
        lat = 3;
        set_op(0, 16'd7, 16'd100);
        req = 4'b0001;
        n   = cyc;
        g0  = go_cnt;
        wait_resp(50, ok, at);
        req = '0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_timeout: got no resp_valid want resp_valid");
        end
        n_checks++;
        if (at != n + 3 + lat) begin
            n_fail++;
            $display("FAIL single_latency: got cycle %0d want %0d", at, n + 3 + lat);
        end
        n_checks++;
        if (go_cnt != g0 + 1 || last_go != n + 1) begin
            n_fail++;
            $display("FAIL single_go: got %0d pulses at %0d want 1 at %0d", go_cnt - g0, last_go, n + 1);
        end
        n_checks++;
        if ({resp_ch, resp_quotient, resp_err, ack} !== {3'd0, 16'd14, 1'b0, 4'b0001}) begin
            n_fail++;
            $display("FAIL single_resp: got ch=%0d q=%0d err=%b ack=%b want ch=0 q=14 err=0 ack=0001",
                     resp_ch, resp_quotient, resp_err, ack);
        end
        @(negedge clk);
        n_checks++;
        if ({resp_valid, ack} !== '0) begin
            n_fail++;
            $display("FAIL single_pulse: got valid=%b ack=%b want 0 0", resp_valid, ack);
        end
    endtask

    task automatic test_rr_held();
        bit ok;
        int unsigned g, at;
        int unsigned order [5] = '{0, 1, 2, 3, 0};
        pulse_reset();
        for (int unsigned i = 0; i < NCH; i++) set_op(i, 16'(i + 1), 16'd1000);
        lat = $urandom_range(1, 20);
        req = 4'b1111;
        g   = cyc;
        for (int k = 0; k < 5; k++) begin
            wait_resp(60, ok, at);
            n_checks++;
            if (!ok || at != g + 3 + lat) begin
                n_fail++;
                $display("FAIL rr_latency[%0d]: got ok=%b cycle %0d want cycle %0d", k, ok, at, g + 3 + lat);
            end
            n_checks++;
            if (resp_ch !== 3'(order[k]) || ack !== 4'(1 << order[k])) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got ch=%0d ack=%b want ch=%0d", k, resp_ch, ack, order[k]);
            end
            n_checks++;
            if (resp_quotient !== 16'(1000 / (order[k] + 1)) || resp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_quot[%0d]: got %0d err=%b want %0d err=0", k, resp_quotient, resp_err,
                         1000 / (order[k] + 1));
            end
            lat = $urandom_range(1, 20);
            g   = cyc + 1;
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_zero_div();
        bit ok;
        int unsigned n, at, g0;
        set_op(2, 16'd0, 16'd55);
        req = 4'b0100;
        n   = cyc;
        g0  = go_cnt;
        wait_resp(10, ok, at);
        req = '0;
        n_checks++;
        if (!ok || at != n + 1) begin
            n_fail++;
            $display("FAIL zero_latency: got ok=%b cycle %0d want cycle %0d", ok, at, n + 1);
        end
        n_checks++;
        if ({resp_ch, resp_quotient, resp_err, ack} !== {3'd2, 16'hFFFF, 1'b1, 4'b0100}) begin
            n_fail++;
            $display("FAIL zero_resp: got ch=%0d q=%h err=%b ack=%b want ch=2 q=ffff err=1 ack=0100",
                     resp_ch, resp_quotient, resp_err, ack);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (go_cnt != g0) begin
            n_fail++;
            $display("FAIL zero_go: got %0d go pulses want 0", go_cnt - g0);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int unsigned n, at;
        stuck = 1'b1;
        lat   = 1;
        set_op(3, 16'd5, 16'd9);
        req = 4'b1000;
        n   = cyc;
        wait_resp(TIMEOUT + 20, ok, at);
        req = '0;
        n_checks++;
        if (!ok || at != n + TIMEOUT + 3) begin
            n_fail++;
            $display("FAIL tmo_latency: got ok=%b cycle %0d want cycle %0d", ok, at, n + TIMEOUT + 3);
        end
        n_checks++;
        if ({resp_ch, resp_quotient, resp_err, ack} !== {3'd3, 16'hFFFF, 1'b1, 4'b1000}) begin
            n_fail++;
            $display("FAIL tmo_resp: got ch=%0d q=%h err=%b ack=%b want ch=3 q=ffff err=1 ack=1000",
                     resp_ch, resp_quotient, resp_err, ack);
        end
        stuck = 1'b0;
        @(negedge clk);
        set_op(1, 16'd5, 16'd0);
        req = 4'b0010;
        n   = cyc;
        wait_resp(60, ok, at);
        req = '0;
        n_checks++;
        if (!ok || at != n + 4 || resp_quotient !== 16'd0 || resp_err !== 1'b0 || resp_ch !== 3'd1) begin
            n_fail++;
            $display("FAIL dvd0: got ok=%b cycle %0d q=%0d err=%b ch=%0d want cycle %0d q=0 err=0 ch=1",
                     ok, at, resp_quotient, resp_err, resp_ch, n + 4);
        end
        @(negedge clk);
        lat = $urandom_range(1, 30);
        set_op(0, 16'd1, 16'hFFFF);
        req = 4'b0001;
        n   = cyc;
        wait_resp(60, ok, at);
        req = '0;
        n_checks++;
        if (!ok || at != n + 3 + lat || resp_quotient !== 16'hFFFF || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL maxq: got ok=%b cycle %0d q=%h err=%b want cycle %0d q=ffff err=0",
                     ok, at, resp_quotient, resp_err, n + 3 + lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        int unsigned at, a0;
        lat = 5;
        set_op(2, 16'd3, 16'd20);
        req = 4'b0100;
        // done rises in cycle n+2+lat; reset is applied in that same cycle
        repeat (2 + 5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_busy: got busy=%b valid=%b want 1 0", busy, resp_valid);
        end
        a0  = act_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        n_checks++;
        if ({ack, resp_valid, busy, div_go, resp_ch, resp_quotient, resp_err, div_divisor, div_dividend} !== '0) begin
            n_fail++;
            $display("FAIL mid_outputs: got busy=%b valid=%b ack=%b divbus=%h want all 0",
                     busy, resp_valid, ack, {div_divisor, div_dividend});
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid || ack != '0) seen = 1'b1;
        end
        n_checks++;
        if (seen || act_cnt != a0) begin
            n_fail++;
            $display("FAIL mid_noack: got %0d completions want 0", act_cnt - a0);
        end
        lat = 2;
        set_op(1, 16'd4, 16'd40);
        set_op(3, 16'd2, 16'd8);
        req = 4'b1010;
        wait_resp(60, ok, at);
        req = 4'b1000;
        n_checks++;
        if (!ok || resp_ch !== 3'd1 || resp_quotient !== 16'd10) begin
            n_fail++;
            $display("FAIL mid_ptr: got ok=%b ch=%0d q=%0d want ch=1 q=10", ok, resp_ch, resp_quotient);
        end
        wait_resp(60, ok, at);
        req = '0;
        n_checks++;
        if (!ok || resp_ch !== 3'd3 || resp_quotient !== 16'd4) begin
            n_fail++;
            $display("FAIL mid_next: got ok=%b ch=%0d q=%0d want ch=3 q=4", ok, resp_ch, resp_quotient);
        end
        @(negedge clk);
    endtask

    // Randomized traffic: requesters hold until acked, then may re-raise at once
    task automatic test_random();
        bit ok;
        int unsigned at, g, ptr_m, exp_ch, exp_at;
        logic [NCH-1:0] pend;
        logic [15:0] a [NCH];
        logic [15:0] b [NCH];
        logic [15:0] exp_q;
        bit exp_err, found;
        pulse_reset();
        ptr_m = 0;
        pend  = '0;
        for (int it = 0; it < 60; it++) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (!pend[c] && ($urandom_range(0, 1) == 1)) begin
                    pend[c] = 1'b1;
                    a[c]    = 16'($urandom);
                    case ($urandom_range(0, 7))
                        0:       b[c] = 16'd0;
                        1:       b[c] = 16'd1;
                        2, 3, 4: b[c] = 16'($urandom_range(1, 255));
                        default: b[c] = 16'($urandom_range(1, 65535));
                    endcase
                    set_op(c, b[c], a[c]);
                end
            end
            if (pend == '0) begin
                pend[0] = 1'b1;
                a[0]    = 16'd321;
                b[0]    = 16'd3;
                set_op(0, b[0], a[0]);
            end
            req   = pend;
            lat   = $urandom_range(1, 30);
            g     = busy ? cyc + 1 : cyc;
            found = 1'b0;
            exp_ch = 0;
            for (int unsigned k = 0; k < NCH; k++) begin
                if (!found && pend[(ptr_m + k) % NCH]) begin
                    found  = 1'b1;
                    exp_ch = (ptr_m + k) % NCH;
                end
            end
            exp_err = (b[exp_ch] == 16'd0);
            exp_q   = exp_err ? 16'hFFFF : a[exp_ch] / b[exp_ch];
            exp_at  = exp_err ? g + 1 : g + 3 + lat;
            wait_resp(80, ok, at);
            n_checks++;
            if (!ok || at != exp_at) begin
                n_fail++;
                $display("FAIL rnd_latency[%0d]: got ok=%b cycle %0d want cycle %0d", it, ok, at, exp_at);
            end
            n_checks++;
            if (resp_ch !== 3'(exp_ch) || ack !== 4'(1 << exp_ch)) begin
                n_fail++;
                $display("FAIL rnd_grant[%0d]: got ch=%0d ack=%b want ch=%0d", it, resp_ch, ack, exp_ch);
            end
            n_checks++;
            if (resp_quotient !== exp_q || resp_err !== exp_err) begin
                n_fail++;
                $display("FAIL rnd_result[%0d]: got q=%h err=%b want q=%h err=%b", it, resp_quotient,
                         resp_err, exp_q, exp_err);
            end
            pend[exp_ch] = 1'b0;
            ptr_m        = (exp_ch + 1) % NCH;
            if (!ok) begin
                // Resynchronise model and DUT before carrying on
                pulse_reset();
                ptr_m = 0;
                pend  = '0;
            end
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_held();
        test_zero_div();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
